lcd_write_ctrl: RTL and testbench
=================================

LCD_WRITE_CTRL -- requirements
Module: lcd_write_ctrl

Interface
REQ-001 SHALL have parameter T_SETUP, default 2, meaning cycles data/RS are stable before E rises (40 ns at 50 MHz).
REQ-002 SHALL have parameter T_PULSE, default 12, meaning cycles E is high (240 ns).
REQ-003 SHALL have parameter T_HOLD, default 1, meaning cycles data/RS are held after E falls.
REQ-004 SHALL have parameter T_GAP, default 50, meaning cycles between upper and lower nibble (1 us).
REQ-005 SHALL have parameter T_WAIT, default 2000, meaning post-command wait cycles (40 us).
REQ-006 SHALL have parameter T_WAIT_LONG, default 82000, meaning post-command wait cycles for clear/home (1.64 ms).
REQ-007 SHALL have port Clock, input, 1, the only clock; all flops rising-edge.
REQ-008 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port iWrite, input, 1, one-cycle request strobe from CPU LCD instruction.
REQ-010 SHALL have port iData, input, 8, command/character byte.
REQ-011 SHALL have port iRS, input, 1, register select (0 command, 1 data).
REQ-012 SHALL have port iNibbleOnly, input, 1, send only iData[7:4] (init sequence).
REQ-013 SHALL have ports oLCD_E, oLCD_RS, oLCD_RW (1 each) and oLCD_D (4), outputs to the Spartan-3E LCD pins.
REQ-014 SHALL have port oBusy, output, 1, high while a transfer or wait is in progress.
REQ-015 SHALL have port oDone, output, 1, one-cycle pulse when a request fully completes.

Function
REQ-016 SHALL implement states IDLE, SETUP, PULSE, HOLD, GAP, WAIT using a single cycle down-counter.
REQ-017 SHALL, in IDLE with iWrite=1, latch iData, iRS and iNibbleOnly and enter SETUP on the next edge; the latched values are used for the whole transfer.
REQ-018 SHALL drive oLCD_D = latched upper nibble and oLCD_RS = latched RS from the first SETUP cycle; E=0 for T_SETUP cycles.
REQ-019 SHALL hold oLCD_E=1 for exactly T_PULSE cycles in PULSE, then E=0 for T_HOLD cycles in HOLD with data/RS unchanged.
REQ-020 SHALL, after HOLD of the upper nibble in byte mode, spend T_GAP cycles in GAP, then repeat SETUP/PULSE/HOLD with the lower nibble.
REQ-021 SHALL, after the final HOLD, enter WAIT for T_WAIT_LONG cycles if latched RS=0 and byte is 8'h01 or 8'h02, otherwise T_WAIT cycles.
REQ-022 SHALL, in nibble-only mode, skip GAP and the lower nibble and always use T_WAIT.
REQ-023 SHALL assert oBusy in every non-IDLE state; byte transfer busy time with defaults = 2+12+1+50+2+12+1+2000 = 2080 cycles.
REQ-024 SHALL pulse oDone for one cycle, the first IDLE cycle after WAIT; iWrite in that cycle SHALL be accepted.
REQ-025 SHALL ignore iWrite while oBusy=1 (no queuing, no corruption of latched data).
REQ-026 SHALL tie oLCD_RW to 0 (write-only interface).
REQ-027 SHALL size the counter to 18 bits; a parameter value of 0 SHALL be treated as 1 cycle.

Reset
REQ-028 SHALL, on Reset=0, immediately force state IDLE, counter 0, oLCD_E=0, oLCD_RS=0, oLCD_D=0, oBusy=0, oDone=0, latched registers 0.
REQ-029 SHALL abort any transfer on reset mid-operation (E drops asynchronously); no oDone for the aborted request.
REQ-030 SHALL accept a new iWrite on the first edge after Reset deasserts.

Structure
REQ-031 SHALL place the state encodings and default timing constants in the shared Definitions header alongside opcode definitions.
REQ-032 SHALL use one sub-module lcd_delay_counter (load, value, zero flag); all other logic is in lcd_write_ctrl.

Verification
REQ-033 Byte 8'h4D, iRS=1 -> D=4 then D=D, E high 12 cycles each, RS=1 throughout, oDone at cycle 2081, busy 2080 cycles.
REQ-034 Nibble-only 8'h30, iRS=0 -> single E pulse with D=3, oDone after 2+12+1+2000 cycles.
REQ-035 Command 8'h01, iRS=0 -> WAIT of 82000 cycles, oDone after 82080 busy cycles.
REQ-036 iWrite 8'h41 pulsed during PULSE of a 8'h4D transfer -> ignored; second-nibble D=D; only one oDone.
REQ-037 Reset=0 while E high -> E=0 same cycle, all outputs 0; next iWrite 8'h28 completes normally.
REQ-038 iWrite 8'h06 asserted in oDone cycle -> accepted, SETUP next cycle, D=0 then D=6.

Source files
------------

// File: rtl/lcd_write_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lcd_write_ctrl_pkg
// Shared definitions for the character-LCD write path: controller state
// encoding, delay-counter width, default bus timing (50 MHz clock) and the
// HD44780 opcodes the controller needs to recognise.
// ---------------------------------------------------------------------------
package lcd_write_ctrl_pkg;

  // Wide enough for the longest post-command wait (82000 cycles).
  localparam int CNT_W = 18;

  // Default timing in clock cycles at 50 MHz.
  localparam int DEF_T_SETUP     = 2;      // 40 ns
  localparam int DEF_T_PULSE     = 12;     // 240 ns
  localparam int DEF_T_HOLD      = 1;      // 20 ns
  localparam int DEF_T_GAP       = 50;     // 1 us
  localparam int DEF_T_WAIT      = 2000;   // 40 us
  localparam int DEF_T_WAIT_LONG = 82000;  // 1.64 ms

  // Opcodes; clear and home are the only slow commands.
  localparam logic [7:0] OP_CLEAR      = 8'h01;
  localparam logic [7:0] OP_HOME       = 8'h02;
  localparam logic [7:0] OP_ENTRY_MODE = 8'h06;
  localparam logic [7:0] OP_DISP_CTRL  = 8'h0C;
  localparam logic [7:0] OP_FUNC_SET   = 8'h28;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_WAIT  = 3'd5
  } lcd_state_t;

  // Reload value for a phase lasting 'cycles' cycles. The counter leaves a
  // phase on the cycle it reads zero, so it is loaded with cycles-1; a zero
  // length phase is stretched to one cycle.
  function automatic logic [CNT_W-1:0] dly_load(input int cycles);
    if (cycles <= 1) return '0;
    else             return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// ---------------------------------------------------------------------------
// lcd_delay_counter
// Loadable down-counter that times every phase of an LCD write.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   load  : load 'value' on this edge (takes priority over counting)
//   value : reload value (phase length minus one)
//   zero  : count is zero; the phase ends in this cycle
// The count decrements until it reaches zero and then stays there.
// ---------------------------------------------------------------------------
module lcd_delay_counter
  import lcd_write_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          count <= '0;
    else if (load)       count <= value;
    else if (count != '0) count <= count - CNT_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_write_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_write_ctrl
// 4-bit write-only sequencer for the Spartan-3E character LCD. A one-cycle
// request is latched and sent as upper nibble, gap, lower nibble (or the
// upper nibble alone in nibble-only mode), followed by the command
// execution wait. Clear/home commands get the long wait.
//   Clock       : clock, all flops rising-edge
//   Reset       : asynchronous active-low reset, aborts any transfer
//   iWrite      : request strobe, accepted only while idle
//   iData       : command/character byte
//   iRS         : register select (0 command, 1 data)
//   iNibbleOnly : send iData[7:4] only (power-up init sequence)
//   oLCD_E/RS/RW/D : LCD pins (RW tied low)
//   oBusy       : transfer or wait in progress
//   oDone       : one-cycle pulse in the first idle cycle after a request
// ---------------------------------------------------------------------------
module lcd_write_ctrl
  import lcd_write_ctrl_pkg::*;
#(
  parameter int T_SETUP     = DEF_T_SETUP,
  parameter int T_PULSE     = DEF_T_PULSE,
  parameter int T_HOLD      = DEF_T_HOLD,
  parameter int T_GAP       = DEF_T_GAP,
  parameter int T_WAIT      = DEF_T_WAIT,
  parameter int T_WAIT_LONG = DEF_T_WAIT_LONG
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWrite,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iNibbleOnly,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_D,
  output logic       oBusy,
  output logic       oDone
);

  lcd_state_t       state, state_nxt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  logic [7:0]       data_q;
  logic             rs_q;
  logic             nib_only_q;
  logic             lower_q;     // 1 while the lower nibble is being sent
  logic             done_q;

  logic             accept;
  logic             long_wait;
  logic [CNT_W-1:0] wait_load;

  assign accept    = (state == ST_IDLE) && iWrite;
  assign long_wait = !nib_only_q && !rs_q &&
                     ((data_q == OP_CLEAR) || (data_q == OP_HOME));
  assign wait_load = long_wait ? dly_load(T_WAIT_LONG) : dly_load(T_WAIT);

  lcd_delay_counter u_dly (
    .clk   (Clock),
    .rst_n (Reset),
    .load  (cnt_load),
    .value (cnt_val),
    .zero  (cnt_zero)
  );

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Request latch, nibble select and completion flag
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      data_q     <= '0;
      rs_q       <= 1'b0;
      nib_only_q <= 1'b0;
      lower_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Registered so the pulse lands in the first idle cycle after WAIT.
      done_q <= (state == ST_WAIT) && cnt_zero;
      if (accept) begin
        data_q     <= iData;
        rs_q       <= iRS;
        nib_only_q <= iNibbleOnly;
        lower_q    <= 1'b0;
      end else if ((state == ST_GAP) && cnt_zero) begin
        lower_q    <= 1'b1;
      end
    end
  end

  // Next state; every transition reloads the counter for the new phase.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state)
      ST_IDLE: begin
        if (iWrite) begin
          state_nxt = ST_SETUP;
          cnt_load  = 1'b1;
          cnt_val   = dly_load(T_SETUP);
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_nxt = ST_PULSE;
          cnt_load  = 1'b1;
          cnt_val   = dly_load(T_PULSE);
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_nxt = ST_HOLD;
          cnt_load  = 1'b1;
          cnt_val   = dly_load(T_HOLD);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          if (!lower_q && !nib_only_q) begin
            state_nxt = ST_GAP;
            cnt_val   = dly_load(T_GAP);
          end else begin
            state_nxt = ST_WAIT;
            cnt_val   = wait_load;
          end
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_nxt = ST_SETUP;
          cnt_load  = 1'b1;
          cnt_val   = dly_load(T_SETUP);
        end
      end
      ST_WAIT: begin
        if (cnt_zero) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs; D and RS are driven only while busy so idle/reset shows zeros.
  always_comb begin
    oBusy   = (state != ST_IDLE);
    oLCD_E  = (state == ST_PULSE);
    oLCD_RS = 1'b0;
    oLCD_D  = 4'h0;
    if (state != ST_IDLE) begin
      oLCD_RS = rs_q;
      oLCD_D  = lower_q ? data_q[3:0] : data_q[7:4];
    end
  end

  assign oLCD_RW = 1'b0;
  assign oDone   = done_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_write_ctrl
// Directed bench for lcd_write_ctrl with shortened waits so the long-wait
// path fits a short run. T_HOLD is set to 0, which the design stretches to
// one cycle. Cycle 0 is the cycle in which iWrite is presented; outputs are
// sampled on the falling edge.
//   byte busy   = 2+12+1+50+2+12+1+200 = 280, oDone at cycle 281
//   nibble busy = 2+12+1+200           = 215, oDone at cycle 216
//   clear busy  = 2+12+1+50+2+12+1+900 = 980, oDone at cycle 981
//   first E-high cycle = 1 + T_SETUP = 3
// ---------------------------------------------------------------------------
module tb_lcd_write_ctrl;

  localparam int P_SETUP = 2;
  localparam int P_PULSE = 12;
  localparam int P_HOLD  = 0;
  localparam int P_GAP   = 50;
  localparam int P_WAIT  = 200;
  localparam int P_LONG  = 900;

  localparam int BYTE_BUSY  = 280;
  localparam int NIB_BUSY   = 215;
  localparam int CLEAR_BUSY = 980;
  localparam int E_FIRST    = 3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iWrite;
  logic [7:0] iData;
  logic       iRS;
  logic       iNibbleOnly;
  logic       oLCD_E, oLCD_RS, oLCD_RW, oBusy, oDone;
  logic [3:0] oLCD_D;

  int checks = 0;
  int errors = 0;

  // Per-transfer observations
  int r_busy, r_done_cyc, r_done_seen, r_pulses, r_e_first, r_rs_bad, r_rw_bad;
  int r_w [2];
  int r_d [2];

  lcd_write_ctrl #(
    .T_SETUP     (P_SETUP),
    .T_PULSE     (P_PULSE),
    .T_HOLD      (P_HOLD),
    .T_GAP       (P_GAP),
    .T_WAIT      (P_WAIT),
    .T_WAIT_LONG (P_LONG)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iWrite      (iWrite),
    .iData       (iData),
    .iRS         (iRS),
    .iNibbleOnly (iNibbleOnly),
    .oLCD_E      (oLCD_E),
    .oLCD_RS     (oLCD_RS),
    .oLCD_RW     (oLCD_RW),
    .oLCD_D      (oLCD_D),
    .oBusy       (oBusy),
    .oDone       (oDone)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents a request in the current cycle (caller is at a falling edge)
  // and watches until oDone or the budget runs out. Inputs are scrambled
  // after acceptance to show the latched copy is used; an optional 8'h41
  // request is pulsed at cycle 'inj'. Returns at the falling edge of the
  // oDone cycle.
  task automatic run_xfer(input logic [7:0] d, input logic rs, input logic nib,
                          input int inj, input int budget);
    logic prev_e;
    int   c;
    iData = d; iRS = rs; iNibbleOnly = nib; iWrite = 1'b1;
    r_busy = 0; r_done_cyc = 0; r_done_seen = 0; r_pulses = 0;
    r_e_first = 0; r_rs_bad = 0; r_rw_bad = 0;
    r_w[0] = 0; r_w[1] = 0; r_d[0] = -1; r_d[1] = -1;
    prev_e = 1'b0;
    c = 0;
    while (c < budget && r_done_seen == 0) begin
      @(negedge Clock);
      c++;
      iWrite      = (c == inj);
      iData       = (c == inj) ? 8'h41 : 8'hFF;
      iRS         = ~rs;
      iNibbleOnly = ~nib;
      if (oBusy) r_busy++;
      if (oBusy && oLCD_RS !== rs) r_rs_bad++;
      if (oLCD_RW !== 1'b0) r_rw_bad++;
      if (oLCD_E && !prev_e) begin
        if (r_pulses == 0) r_e_first = c;
        if (r_pulses < 2) r_d[r_pulses] = int'(oLCD_D);
        r_pulses++;
      end
      if (oLCD_E && r_pulses >= 1 && r_pulses <= 2) r_w[r_pulses-1]++;
      prev_e = oLCD_E;
      if (oDone) begin
        r_done_seen = 1;
        r_done_cyc  = c;
      end
    end
    iWrite = 1'b0;
  endtask

  task automatic verify(input string t, input int busy_exp, input int pulses_exp,
                        input int d0, input int d1);
    check({t, "_done_seen"}, r_done_seen, 1);
    check({t, "_busy"},      r_busy, busy_exp);
    check({t, "_done_cyc"},  r_done_cyc, busy_exp + 1);
    check({t, "_pulses"},    r_pulses, pulses_exp);
    check({t, "_e_first"},   r_e_first, E_FIRST);
    check({t, "_w0"},        r_w[0], P_PULSE);
    check({t, "_d0"},        r_d[0], d0);
    if (pulses_exp == 2) begin
      check({t, "_w1"}, r_w[1], P_PULSE);
      check({t, "_d1"}, r_d[1], d1);
    end
    check({t, "_rs_stable"}, r_rs_bad, 0);
    check({t, "_rw_low"},    r_rw_bad, 0);
  endtask

  // Idles a few cycles, confirming nothing restarts and no extra oDone.
  task automatic quiet(input string t, input int n);
    int busy_cnt, done_cnt;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      if (oBusy) busy_cnt++;
      if (oDone) done_cnt++;
    end
    check({t, "_quiet_busy"}, busy_cnt, 0);
    check({t, "_quiet_done"}, done_cnt, 0);
  endtask

  initial begin
    Reset = 1'b0; iWrite = 1'b0; iData = 8'h00; iRS = 1'b0; iNibbleOnly = 1'b0;
    #12;
    check("rst_e",    int'(oLCD_E), 0);
    check("rst_rs",   int'(oLCD_RS), 0);
    check("rst_rw",   int'(oLCD_RW), 0);
    check("rst_d",    int'(oLCD_D), 0);
    check("rst_busy", int'(oBusy), 0);
    check("rst_done", int'(oDone), 0);

    // Release reset and request in the same cycle: accepted on first edge.
    @(negedge Clock);
    Reset = 1'b1;
    run_xfer(8'h4D, 1'b1, 1'b0, 0, 1200);
    verify("byte4D", BYTE_BUSY, 2, 4'h4, 4'hD);
    quiet("byte4D", 4);

    run_xfer(8'h30, 1'b0, 1'b1, 0, 1200);
    verify("nib30", NIB_BUSY, 1, 4'h3, 0);
    quiet("nib30", 3);

    run_xfer(8'h01, 1'b0, 1'b0, 0, 1200);
    verify("clear01", CLEAR_BUSY, 2, 4'h0, 4'h1);
    quiet("clear01", 3);

    // 8'h02 as data is not a slow command.
    run_xfer(8'h02, 1'b1, 1'b0, 0, 1200);
    verify("data02", BYTE_BUSY, 2, 4'h0, 4'h2);
    quiet("data02", 3);

    // Nibble-only never takes the long wait, even for 8'h01.
    run_xfer(8'h01, 1'b0, 1'b1, 0, 1200);
    verify("nib01", NIB_BUSY, 1, 4'h0, 0);
    quiet("nib01", 3);

    // Request 8'h41 during the first E pulse is dropped.
    run_xfer(8'h4D, 1'b1, 1'b0, 5, 1200);
    verify("inj4D", BYTE_BUSY, 2, 4'h4, 4'hD);
    quiet("inj4D", 10);

    // Back-to-back: new request presented in the oDone cycle.
    run_xfer(8'h0C, 1'b0, 1'b0, 0, 1200);
    verify("pre0C", BYTE_BUSY, 2, 4'h0, 4'hC);
    run_xfer(8'h06, 1'b0, 1'b0, 0, 1200);
    verify("chain06", BYTE_BUSY, 2, 4'h0, 4'h6);
    quiet("chain06", 3);

    // Asynchronous reset while E is high, then a normal transfer.
    iData = 8'h4D; iRS = 1'b1; iNibbleOnly = 1'b0; iWrite = 1'b1;
    @(negedge Clock);
    iWrite = 1'b0;
    repeat (4) @(negedge Clock);
    check("abort_e_high", int'(oLCD_E), 1);
    #2 Reset = 1'b0;
    #1;
    check("abort_e",    int'(oLCD_E), 0);
    check("abort_rs",   int'(oLCD_RS), 0);
    check("abort_d",    int'(oLCD_D), 0);
    check("abort_busy", int'(oBusy), 0);
    check("abort_done", int'(oDone), 0);
    @(negedge Clock);
    Reset = 1'b1;
    run_xfer(8'h28, 1'b0, 1'b0, 0, 1200);
    verify("post28", BYTE_BUSY, 2, 4'h2, 4'h8);
    quiet("post28", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
